// File: rtl/regfile_exec_seq.sv
// -----------------------------------------------------------------------------
// regfile_exec_seq
//
// Purpose:
//   Execute sequencer between the instruction decoder and the register file.
//   It accepts one decoded op per valid/ready handshake and reads both source
//   operands from the register file. It computes the ALU result and writes it
//   back through the register-file write port. It is the only driver of the
//   register-file ports.
//
//   The op passes through IDLE -> READ -> EXEC -> WB -> IDLE.
//   Single-cycle ops spend one cycle in EXEC. MUL uses a shift-add loop that
//   consumes one multiplier bit per cycle, so it stays DATA_W cycles in EXEC.
//
// Parameters:
//   DATA_W  operand/result width (register-file data width)
//   ADDR_W  register address width (register-file address width)
//
// Ports:
//   clk          in   rising-edge clock, shared with the register file
//   rst_n        in   asynchronous active-low reset
//   instr_valid  in   decoded op present
//   instr_ready  out  sequencer can take an op (high only in IDLE)
//   instr_op     in   000 ADD,001 SUB,010 AND,011 OR,100 XOR,101 SHL,110 MUL,111 NOP
//   instr_rd     in   destination register
//   instr_rs     in   source A register
//   instr_rt     in   source B register
//   rdAddrA      out  register-file read address A (registered)
//   rdAddrB      out  register-file read address B (registered)
//   rdDataA      in   register-file read data A (combinational from rdAddrA)
//   rdDataB      in   register-file read data B (combinational from rdAddrB)
//   write        out  register-file write enable, one-cycle pulse in WB
//   wrAddr       out  write address, holds after WB
//   wrData       out  write data, holds after WB
//   done         out  one-cycle completion pulse, same cycle as write
//   flag_z       out  last result was zero
//   flag_c       out  ADD carry-out / SUB borrow, 0 for other ops
// -----------------------------------------------------------------------------
module regfile_exec_seq #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [2:0]        instr_op,
  input  logic [ADDR_W-1:0] instr_rd,
  input  logic [ADDR_W-1:0] instr_rs,
  input  logic [ADDR_W-1:0] instr_rt,
  output logic [ADDR_W-1:0] rdAddrA,
  output logic [ADDR_W-1:0] rdAddrB,
  input  logic [DATA_W-1:0] rdDataA,
  input  logic [DATA_W-1:0] rdDataB,
  output logic              write,
  output logic [ADDR_W-1:0] wrAddr,
  output logic [DATA_W-1:0] wrData,
  output logic              done,
  output logic              flag_z,
  output logic              flag_c
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_NOP = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_t;

  state_t              state_q;
  logic [2:0]          op_q;
  logic [ADDR_W-1:0]   rd_q;
  logic [DATA_W-1:0]   opA_q;
  logic [DATA_W-1:0]   opB_q;
  logic [DATA_W-1:0]   acc_q;
  logic [CNT_W-1:0]    cnt_q;

  logic [ADDR_W-1:0]   rdAddrA_q;
  logic [ADDR_W-1:0]   rdAddrB_q;
  logic                write_q;
  logic [ADDR_W-1:0]   wrAddr_q;
  logic [DATA_W-1:0]   wrData_q;
  logic                done_q;
  logic                flagZ_q;
  logic                flagC_q;

  logic [DATA_W-1:0]   aluRes_d;
  logic                aluCarry_d;
  logic [DATA_W-1:0]   mulSum_d;
  logic                mulLast_d;
  logic [DATA_W-1:0]   execRes_d;
  logic                execCarry_d;
  logic                execFinish_d;

  // Every output comes straight from a register.
  assign instr_ready = (state_q == IDLE);
  assign rdAddrA     = rdAddrA_q;
  assign rdAddrB     = rdAddrB_q;
  assign write       = write_q;
  assign wrAddr      = wrAddr_q;
  assign wrData      = wrData_q;
  assign done        = done_q;
  assign flag_z      = flagZ_q;
  assign flag_c      = flagC_q;

  // Single-cycle ALU working on the operands captured in READ.
  // Sums are done one bit wider so the ADD carry-out falls out directly.
  always_comb begin
    aluRes_d   = '0;
    aluCarry_d = 1'b0;
    unique case (op_q)
      OP_ADD: {aluCarry_d, aluRes_d} = {1'b0, opA_q} + {1'b0, opB_q};
      OP_SUB: begin
        aluRes_d   = opA_q - opB_q;
        aluCarry_d = (opA_q < opB_q);
      end
      OP_AND: aluRes_d = opA_q & opB_q;
      OP_OR:  aluRes_d = opA_q | opB_q;
      OP_XOR: aluRes_d = opA_q ^ opB_q;
      OP_SHL: aluRes_d = opA_q << opB_q[3:0];
      OP_MUL: aluRes_d = '0;
      OP_NOP: aluRes_d = '0;
      default: aluRes_d = '0;
    endcase
  end

  // Shift-add multiplier step.
  // During MUL, opA_q is the multiplicand and shifts left each cycle.
  // opB_q is the multiplier and shifts right each cycle.
  // acc_q holds the partial product.
  // On the last bit the updated sum is already the final result, so it goes
  // straight to wrData without an extra cycle.
  always_comb begin
    mulSum_d     = acc_q + (opB_q[0] ? opA_q : '0);
    mulLast_d    = (cnt_q == CNT_W'(DATA_W - 1));
    execRes_d    = aluRes_d;
    execCarry_d  = aluCarry_d;
    execFinish_d = 1'b1;
    if (op_q == OP_MUL) begin
      execRes_d    = mulSum_d;
      execCarry_d  = 1'b0;
      execFinish_d = mulLast_d;
    end
  end

  // Sequencer FSM.
  // write and done default low each cycle, so they only pulse on the
  // EXEC -> WB edge and are therefore high for exactly the WB cycle.
  // The async reset also clears write, so an op that is cut off never
  // produces a partial write-back.
  // For NOP, wrAddr, wrData and the flags keep their previous values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_q      <= '0;
      rd_q      <= '0;
      opA_q     <= '0;
      opB_q     <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      rdAddrA_q <= '0;
      rdAddrB_q <= '0;
      write_q   <= 1'b0;
      wrAddr_q  <= '0;
      wrData_q  <= '0;
      done_q    <= 1'b0;
      flagZ_q   <= 1'b0;
      flagC_q   <= 1'b0;
    end else begin
      write_q <= 1'b0;
      done_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (instr_valid) begin
            op_q      <= instr_op;
            rd_q      <= instr_rd;
            rdAddrA_q <= instr_rs;
            rdAddrB_q <= instr_rt;
            state_q   <= READ;
          end
        end
        READ: begin
          opA_q   <= rdDataA;
          opB_q   <= rdDataB;
          acc_q   <= '0;
          cnt_q   <= '0;
          state_q <= EXEC;
        end
        EXEC: begin
          if (op_q == OP_MUL) begin
            acc_q <= mulSum_d;
            opA_q <= opA_q << 1;
            opB_q <= opB_q >> 1;
            cnt_q <= cnt_q + 1'b1;
          end
          if (execFinish_d) begin
            done_q  <= 1'b1;
            state_q <= WB;
            if (op_q != OP_NOP) begin
              write_q  <= 1'b1;
              wrAddr_q <= rd_q;
              wrData_q <= execRes_d;
              flagZ_q  <= (execRes_d == '0);
              flagC_q  <= execCarry_d;
            end
          end
        end
        WB: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
